// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 mode constants and receiver state type
package vga_pkg;
  localparam int RD = 5;
  localparam int GD = 6;
  localparam int BD = 5;
  localparam int HA = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int VA = 480;
  localparam int VF = 10;
  localparam int VS = 2;
  localparam int VB = 33;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  typedef enum logic [1:0] {SEEK, ACQ, LOCKED} rx_state_e;
endpackage

// File: rtl/vga_sync_meter.sv
// vga_sync_meter: sync edge detect, saturating position counter, period/width check and timeout
module vga_sync_meter #(
  parameter int CW = 12,
  parameter int TOTAL = 800,
  parameter int WIDTH = 96,
  parameter bit TMO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sync,
  input  logic          inc,
  output logic          lead,
  output logic [CW-1:0] cnt_n,
  output logic          viol
);
  localparam logic [CW-1:0] MAX = '1;
  logic          sync_q;
  logic          trail;
  logic [CW-1:0] cnt;
  always_comb begin
    lead = sync & ~sync_q;
    trail = ~sync & sync_q;
    cnt_n = lead ? '0 : (inc && cnt != MAX) ? cnt + 1'b1 : cnt;
    viol = (lead && cnt != CW'(TOTAL - 1)) || (trail && cnt != CW'(WIDTH - 1)) ||
           (TMO && !lead && inc && cnt == MAX - 1'b1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= 1'b0;
      cnt <= '0;
    end else begin
      sync_q <= sync;
      cnt <= cnt_n;
    end
endmodule

// File: rtl/vga_rx.sv
// vga_rx: VGA receiver recovering frame timing and emitting locked active-area pixels
module vga_rx
  import vga_pkg::*;
#(
  parameter int rd = RD,
  parameter int gd = GD,
  parameter int bd = BD,
  parameter int ha = HA,
  parameter int hf = HF,
  parameter int hs = HS,
  parameter int hb = HB,
  parameter int va = VA,
  parameter int vf = VF,
  parameter int vs = VS,
  parameter int vb = VB,
  parameter bit hpol = 1'b0,
  parameter bit vpol = 1'b0,
  parameter int lock_frames = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [rd-1:0]         R,
  input  logic [gd-1:0]         G,
  input  logic [bd-1:0]         B,
  input  logic                  HSync,
  input  logic                  VSync,
  output logic [rd+gd+bd-1:0]   data_o,
  output logic                  valid,
  output logic                  sof,
  output logic                  eol,
  output logic [10:0]           x,
  output logic [10:0]           y,
  output logic                  locked,
  output logic                  err
);
  localparam int DW = rd + gd + bd;
  localparam int HOFF = hs + hb;
  localparam int VOFF = vs + vb;
  localparam int GW = $clog2(lock_frames + 1) + 1;
  logic [DW-1:0] pix1, pix2;
  logic          h1, h2, v1, v2;
  logic          h_lead, v_lead, h_viol, v_viol, act;
  logic [11:0]   hcnt_n, px;
  logic [10:0]   vcnt_n, py;
  logic [GW-1:0] good, good_n, good_inc;
  rx_state_e     state, state_n;
  always_ff @(posedge clk)
    if (rst) {pix1, pix2, h1, h2, v1, v2} <= '0;
    else {pix1, pix2, h1, h2, v1, v2} <= {{R, G, B}, pix1, HSync == hpol, h1, VSync == vpol, v1};
  vga_sync_meter #(.CW(12), .TOTAL(ha + hf + hs + hb), .WIDTH(hs), .TMO(1'b1)) u_h (
    .clk(clk), .rst(rst), .sync(h2), .inc(1'b1), .lead(h_lead), .cnt_n(hcnt_n), .viol(h_viol)
  );
  vga_sync_meter #(.CW(11), .TOTAL(va + vf + vs + vb), .WIDTH(vs), .TMO(1'b0)) u_v (
    .clk(clk), .rst(rst), .sync(v2), .inc(h_lead), .lead(v_lead), .cnt_n(vcnt_n), .viol(v_viol)
  );
  always_comb begin
    good_inc = good + 1'b1;
    state_n = state;
    good_n = good;
    if (state == SEEK) begin
      state_n = v_lead ? ACQ : SEEK;
      good_n = '0;
    end else if (h_viol || v_viol) begin
      state_n = SEEK;
      good_n = '0;
    end else if (state == ACQ && v_lead) begin
      state_n = int'(good_inc) >= lock_frames ? LOCKED : ACQ;
      good_n = good_inc;
    end
    px = hcnt_n - 12'(HOFF);
    py = vcnt_n - 11'(VOFF);
    act = state_n == LOCKED && hcnt_n >= 12'(HOFF) && px < 12'(ha) && vcnt_n >= 11'(VOFF) && py < 11'(va);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= SEEK;
      good <= '0;
      data_o <= '0;
      valid <= 1'b0;
      sof <= 1'b0;
      eol <= 1'b0;
      x <= '0;
      y <= '0;
      locked <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      good <= good_n;
      data_o <= pix2;
      valid <= act;
      sof <= act && px == '0 && py == '0;
      eol <= act && px == 12'(ha - 1);
      x <= act ? px[10:0] : x;
      y <= act ? py : y;
      locked <= state_n == LOCKED;
      err <= (h_viol || v_viol) && state != SEEK;
    end
endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: randomized vga_tx-style stream against a frame-level receiver model, both sync polarities
module tb_vga_rx;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int LF = 2, DW = 16;
  localparam int SK = 0, AQ = 1, LK = 2;
  typedef struct {int t; logic [DW-1:0] d; logic [10:0] x; logic [10:0] y; logic sof; logic eol;} pix_t;
  typedef struct {int t; logic v;} ev_t;
  logic clk = 1'b0, rst = 1'b1, hsync = 1'b0, vsync = 1'b0;
  logic [4:0] r = '0;
  logic [5:0] g = '0;
  logic [4:0] b = '0;
  logic [DW-1:0] data_o[2];
  logic valid[2], sof[2], eol[2], locked[2], err[2];
  logic [10:0] x[2], y[2];
  int cyc = 0, checks = 0, errors = 0;
  int mst = SK, good = 0, since_h = 0;
  pix_t pq[$];
  ev_t lq[$];
  int eq[$], zq[$];
  int pidx[2] = '{0, 0}, eidx[2] = '{0, 0}, lidx[2] = '{0, 0}, zidx[2] = '{0, 0};
  logic lprev[2] = '{1'b0, 1'b0};
  pix_t e;
  vga_rx #(.ha(HA), .hf(HF), .hs(HS), .hb(HB), .va(VA), .vf(VF), .vs(VS), .vb(VB),
           .hpol(1'b0), .vpol(1'b0), .lock_frames(LF)) dut0 (
    .clk(clk), .rst(rst), .R(r), .G(g), .B(b), .HSync(~hsync), .VSync(~vsync),
    .data_o(data_o[0]), .valid(valid[0]), .sof(sof[0]), .eol(eol[0]), .x(x[0]), .y(y[0]),
    .locked(locked[0]), .err(err[0])
  );
  vga_rx #(.ha(HA), .hf(HF), .hs(HS), .hb(HB), .va(VA), .vf(VF), .vs(VS), .vb(VB),
           .hpol(1'b1), .vpol(1'b1), .lock_frames(LF)) dut1 (
    .clk(clk), .rst(rst), .R(r), .G(g), .B(b), .HSync(hsync), .VSync(vsync),
    .data_o(data_o[1]), .valid(valid[1]), .sof(sof[1]), .eol(eol[1]), .x(x[1]), .y(y[1]),
    .locked(locked[1]), .err(err[1])
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input bit h, input bit v, input int line, input int col, input bit hl,
                      input bit vl, input bit bad, input bit rs);
    pix_t p;
    @(posedge clk);
    #1;
    rst = rs;
    hsync = h;
    vsync = v;
    r = 5'($urandom);
    g = 6'($urandom);
    b = 5'($urandom);
    since_h = hl ? 0 : since_h + 1;
    if (rs) begin
      if (mst == LK) lq.push_back('{cyc + 1, 1'b0});
      mst = SK;
      good = 0;
      since_h = 0;
      while (pq.size() > 0 && pq[$].t > cyc) void'(pq.pop_back());
      zq.push_back(cyc + 1);
    end else if ((bad || since_h == 4095) && mst != SK) begin
      if (mst == LK) lq.push_back('{cyc + 3, 1'b0});
      eq.push_back(cyc + 3);
      mst = SK;
      good = 0;
    end else if (vl && mst == SK) mst = AQ;
    else if (vl && mst == AQ) begin
      good++;
      if (good >= LF) begin
        mst = LK;
        lq.push_back('{cyc + 3, 1'b1});
      end
    end
    if (!rs && mst == LK && line >= VS + VB && line < VS + VB + VA && col >= HS + HB && col < HS + HB + HA) begin
      p.t = cyc + 3;
      p.d = {r, g, b};
      p.x = 11'(col - HS - HB);
      p.y = 11'(line - VS - VB);
      p.sof = col == HS + HB && line == VS + VB;
      p.eol = col == HS + HB + HA - 1;
      pq.push_back(p);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, -1, -1, 0, 0, 0, 0);
  endtask
  // kind: 0 clean, 1 line 'arg' one clock short, 2 VSync three lines wide, 3 reset mid active line
  task automatic frame(input int kind, input int arg);
    int vsw, len;
    vsw = kind == 2 ? VS + 1 : VS;
    for (int l = 0; l < VT; l++) begin
      len = (kind == 1 && l == arg) ? HT - 1 : HT;
      for (int c = 0; c < len; c++)
        step(c < HS, l < vsw, l, c, c == 0, l == 0 && c == 0,
             (kind == 1 && l == arg + 1 && c == 0) || (kind == 2 && l == vsw && c == 0),
             kind == 3 && l == 5 && c == HS + HB + 3);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (cyc > 0) for (int d = 0; d < 2; d++) begin
      if (zidx[d] < zq.size() && zq[zidx[d]] == cyc) begin
        zidx[d]++;
        checks++;
        if (data_o[d] != 0 || valid[d] || sof[d] || eol[d] || x[d] != 0 || y[d] != 0 || locked[d] || err[d]) begin
          errors++;
          $display("FAIL dut%0d reset_outputs @%0d: data=%h valid=%b sof=%b eol=%b x=%0d y=%0d locked=%b err=%b, need all zero",
                   d, cyc, data_o[d], valid[d], sof[d], eol[d], x[d], y[d], locked[d], err[d]);
        end
      end
      checks++;
      if (!valid[d] && (sof[d] || eol[d])) begin
        errors++;
        $display("FAIL dut%0d marker_without_valid @%0d: sof=%b eol=%b, need 0", d, cyc, sof[d], eol[d]);
      end
      if (valid[d]) begin
        checks++;
        if (pidx[d] >= pq.size()) begin
          errors++;
          $display("FAIL dut%0d pixel @%0d: valid with x=%0d y=%0d, expected no pixel", d, cyc, x[d], y[d]);
        end else begin
          e = pq[pidx[d]];
          pidx[d]++;
          if (e.t != cyc || e.d != data_o[d] || e.x != x[d] || e.y != y[d] || e.sof != sof[d] || e.eol != eol[d]) begin
            errors++;
            $display("FAIL dut%0d pixel @%0d: got data=%h x=%0d y=%0d sof=%b eol=%b, expected @%0d data=%h x=%0d y=%0d sof=%b eol=%b",
                     d, cyc, data_o[d], x[d], y[d], sof[d], eol[d], e.t, e.d, e.x, e.y, e.sof, e.eol);
          end
        end
      end
      if (err[d]) begin
        checks++;
        if (eidx[d] >= eq.size() || eq[eidx[d]] != cyc) begin
          errors++;
          $display("FAIL dut%0d err_pulse @%0d: got err=1, expected next err @%0d", d, cyc,
                   eidx[d] < eq.size() ? eq[eidx[d]] : -1);
        end
        if (eidx[d] < eq.size()) eidx[d]++;
      end
      if (locked[d] != lprev[d]) begin
        checks++;
        if (lidx[d] >= lq.size() || lq[lidx[d]].t != cyc || lq[lidx[d]].v != locked[d]) begin
          errors++;
          $display("FAIL dut%0d locked_change @%0d: got locked=%b, expected change to %b @%0d", d, cyc, locked[d],
                   lidx[d] < lq.size() ? lq[lidx[d]].v : 1'bx, lidx[d] < lq.size() ? lq[lidx[d]].t : -1);
        end
        if (lidx[d] < lq.size()) lidx[d]++;
        lprev[d] = locked[d];
      end
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, -1, -1, 0, 0, 0, 1);
    idle(4);
    for (int f = 0; f < 4; f++) frame(0, 0);
    frame(1, 5);
    for (int f = 0; f < 3; f++) frame(0, 0);
    idle(5000);
    for (int f = 0; f < 3; f++) frame(0, 0);
    frame(2, 0);
    for (int f = 0; f < 3; f++) frame(0, 0);
    frame(3, 0);
    for (int f = 0; f < 3; f++) frame(0, 0);
    idle(8);
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks += 4;
      if (pidx[d] != pq.size()) begin
        errors++;
        $display("FAIL dut%0d pixel_count: got %0d valid pixels, expected %0d", d, pidx[d], pq.size());
      end
      if (eidx[d] != eq.size()) begin
        errors++;
        $display("FAIL dut%0d err_count: got %0d err pulses, expected %0d", d, eidx[d], eq.size());
      end
      if (lidx[d] != lq.size()) begin
        errors++;
        $display("FAIL dut%0d locked_changes: got %0d, expected %0d", d, lidx[d], lq.size());
      end
      if (zidx[d] != zq.size()) begin
        errors++;
        $display("FAIL dut%0d reset_checks: got %0d, expected %0d", d, zidx[d], zq.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
